// File: rtl/pc_fetch_unit_if.sv
// Fetch-stage bus: control-unit/ULA inputs and instruction/PC outputs of pc_fetch_unit.
// The control side uses the master modport. The fetch unit uses the slave modport.
interface pc_fetch_unit_if;
   logic        en;
   logic        Jump;
   logic        Branch;
   logic        Zero;
   logic [31:0] Instr;
   logic        InstrValid;
   logic [31:0] PC;
   logic [31:0] PCPlus4;
   logic        Halted;

   modport master (
      output en, Jump, Branch, Zero,
      input  Instr, InstrValid, PC, PCPlus4, Halted
   );

   modport slave (
      input  en, Jump, Branch, Zero,
      output Instr, InstrValid, PC, PCPlus4, Halted
   );
endinterface

// File: rtl/pc_fetch_unit.sv
// Instruction fetch stage: PC register, combinational ROM read, next-PC select and RUN/HALT trap.
// Define STEP_MODE_EN to treat en as a raw push-button (synchronized, one step per press).
module pc_fetch_unit #(
   parameter int                         ADDR_W    = 6,
   parameter logic [31:0]                RESET_PC  = 32'h0000_0000,
   // ROM contents: word i occupies bits [32*i +: 32]
   parameter logic [32*(2**ADDR_W)-1:0]  ROM_IMAGE = '0
) (
   input  logic          clk,
   input  logic          reset,
   pc_fetch_unit_if.slave bus
);
   localparam int DEPTH = 2**ADDR_W;

   typedef enum logic {ST_RUN, ST_HALT} state_t;

   state_t              state_reg, state_next;
   logic [31:0]         pc_reg, pc_next;
   logic [31:0]         pc_plus4;
   logic [31:0]         rom_word;
   logic [31:0]         instr;
   logic [31:0]         branch_off;
   logic [ADDR_W-1:0]   rom_idx;
   logic                in_range;
   logic                instr_valid;
   logic                advance;
   logic                pc_load;
   logic [31:0]         rom [DEPTH];

   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_rom
         assign rom[gi] = ROM_IMAGE[gi*32 +: 32];
      end
   endgenerate

`ifdef STEP_MODE_EN
   logic en_sync1_reg, en_sync2_reg, en_prev_reg;

   always_ff @(posedge clk) begin
      if (reset) begin
         en_sync1_reg <= 1'b0;
         en_sync2_reg <= 1'b0;
         en_prev_reg  <= 1'b0;
      end else begin
         en_sync1_reg <= bus.en;
         en_sync2_reg <= en_sync1_reg;
         en_prev_reg  <= en_sync2_reg;
      end
   end

   // One pulse per rising edge of the synchronized button
   assign advance = en_sync2_reg & ~en_prev_reg;
`else
   assign advance = bus.en;
`endif

   assign pc_plus4 = pc_reg + 32'd4;
   assign in_range = (pc_reg[31:ADDR_W+2] == '0);
   assign rom_idx  = pc_reg[ADDR_W+1:2];
   assign rom_word = rom[rom_idx];

   always_comb begin
      state_next  = state_reg;
      instr_valid = 1'b0;
      case (state_reg)
         ST_RUN: begin
            instr_valid = in_range;
            if (!in_range)
               state_next = ST_HALT;
         end
         ST_HALT: begin
            state_next = ST_HALT;
         end
         default: begin
            state_next = ST_HALT;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset)
         state_reg <= ST_RUN;
      else
         state_reg <= state_next;
   end

   assign instr      = instr_valid ? rom_word : 32'h0;
   assign branch_off = {{14{instr[15]}}, instr[15:0], 2'b00};

   always_comb begin
      pc_next = pc_plus4;
      if (bus.Jump)
         pc_next = {pc_plus4[31:28], instr[25:0], 2'b00};
      else if (bus.Branch && bus.Zero)
         pc_next = pc_plus4 + branch_off;
   end

   // An out-of-range PC is frozen so HALT reports the faulting address
   assign pc_load = (state_reg == ST_RUN) && in_range && advance;

   always_ff @(posedge clk) begin
      if (reset)
         pc_reg <= RESET_PC;
      else if (pc_load)
         pc_reg <= pc_next;
   end

   assign bus.Instr      = instr;
   assign bus.InstrValid = instr_valid;
   assign bus.PC         = pc_reg;
   assign bus.PCPlus4    = pc_plus4;
   assign bus.Halted     = (state_reg == ST_HALT);
endmodule
